op_reg_slave: RTL and testbench

OP_REG_SLAVE -- requirements
Module: op_reg_slave

---
 rtl/op_reg_slave.sv | 122 ++++++++++++
 tb/tb_op_reg_slave.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/op_reg_slave.sv
// op_reg_slave: handshaked register slave holding OP_TYPE, SCRATCH, WR_COUNT, ERR_COUNT and STATUS
module op_reg_slave #(
  parameter int         ADDR_BASE   = 10,
  parameter logic [1:0] OP_TYPE_RST = 2'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reg_wr,
  input  logic        reg_rd,
  input  logic [31:0] reg_addr,
  input  logic [31:0] reg_wr_data,
  output logic [31:0] reg_rd_data,
  output logic        reg_ack,
  output logic        reg_err,
  input  logic        bd_wr,
  input  logic [1:0]  bd_op_type,
  output logic [1:0]  op_type
);
  typedef enum logic [1:0] {IDLE, ACCESS, ACK, RELEASE} state_t;
  localparam logic [31:0] BASE = 32'(ADDR_BASE);
  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d, wd_q, wd_d, res_q, res_d;
  logic        wr_q, wr_d, rd_q, rd_d, res_err_q, res_err_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] scratch_q, scratch_d, wrc_q, wrc_d, errc_q, errc_d;
  logic        sticky_q, sticky_d;
  logic        ack_q, ack_d, err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] idx, acc_rdata;
  logic        in_range, acc_err, wr_ok;
  always_comb begin
    idx       = addr_q - BASE;
    in_range  = (addr_q >= BASE) && (idx <= 32'd4);
    acc_err   = (wr_q && rd_q) || !in_range ||
                (wr_q && (idx == 32'd2 || idx == 32'd3)) ||
                (wr_q && idx == 32'd0 && wd_q > 32'd3);
    wr_ok     = wr_q && !acc_err;
    acc_rdata = (acc_err || !rd_q) ? 32'd0 :
                idx == 32'd0 ? {30'd0, op_q} :
                idx == 32'd1 ? scratch_q :
                idx == 32'd2 ? wrc_q :
                idx == 32'd3 ? errc_q : {31'd0, sticky_q};
  end
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wd_d      = wd_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    res_d     = res_q;
    res_err_d = res_err_q;
    op_d      = op_q;
    scratch_d = scratch_q;
    wrc_d     = wrc_q;
    errc_d    = errc_q;
    sticky_d  = sticky_q;
    unique case (state_q)
      IDLE: if (reg_wr || reg_rd) begin
        state_d = ACCESS;
        addr_d  = reg_addr;
        wd_d    = reg_wr_data;
        wr_d    = reg_wr;
        rd_d    = reg_rd;
      end
      ACCESS: begin
        state_d   = ACK;
        res_d     = acc_rdata;
        res_err_d = acc_err;
        op_d      = (wr_ok && idx == 32'd0) ? wd_q[1:0] : op_q;
        scratch_d = (wr_ok && idx == 32'd1) ? wd_q : scratch_q;
        wrc_d     = (wr_ok && wrc_q != 32'hFFFF_FFFF) ? wrc_q + 32'd1 : wrc_q;
        errc_d    = (acc_err && errc_q != 32'hFFFF_FFFF) ? errc_q + 32'd1 : errc_q;
        sticky_d  = acc_err ? 1'b1 : (wr_ok && idx == 32'd4 && wd_q[0]) ? 1'b0 : sticky_q;
      end
      ACK:     state_d = RELEASE;
      RELEASE: if (!reg_wr && !reg_rd) state_d = IDLE;
    endcase
    op_d    = bd_wr ? bd_op_type : op_d;
    ack_d   = state_q == ACK;
    rdata_d = ack_d ? res_q : 32'd0;
    err_d   = ack_d && res_err_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wd_q      <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      res_q     <= '0;
      res_err_q <= 1'b0;
      op_q      <= OP_TYPE_RST;
      scratch_q <= '0;
      wrc_q     <= '0;
      errc_q    <= '0;
      sticky_q  <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wd_q      <= wd_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      res_q     <= res_d;
      res_err_q <= res_err_d;
      op_q      <= op_d;
      scratch_q <= scratch_d;
      wrc_q     <= wrc_d;
      errc_q    <= errc_d;
      sticky_q  <= sticky_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end
  assign reg_ack     = ack_q;
  assign reg_err     = err_q;
  assign reg_rd_data = rdata_q;
  assign op_type     = op_q;
endmodule

// File: tb/tb_op_reg_slave.sv
// tb_op_reg_slave: directed self-checking bench for op_reg_slave
module tb_op_reg_slave;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reg_wr = 1'b0;
  logic        reg_rd = 1'b0;
  logic [31:0] reg_addr = '0;
  logic [31:0] reg_wr_data = '0;
  logic [31:0] reg_rd_data;
  logic        reg_ack;
  logic        reg_err;
  logic        bd_wr = 1'b0;
  logic [1:0]  bd_op_type = '0;
  logic [1:0]  op_type;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] rdata;
  logic        err;
  int          acks;
  op_reg_slave #(.ADDR_BASE(10), .OP_TYPE_RST(2'd0)) dut (
    .clk(clk), .rst_n(rst_n), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_addr(reg_addr), .reg_wr_data(reg_wr_data), .reg_rd_data(reg_rd_data),
    .reg_ack(reg_ack), .reg_err(reg_err), .bd_wr(bd_wr), .bd_op_type(bd_op_type),
    .op_type(op_type)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic xfer(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                      input int hold, input logic bd, input logic [1:0] bd_val,
                      output logic [31:0] rd_o, output logic err_o, output int acks_o);
    int cyc;
    int lat;
    cyc = 0;
    lat = 0;
    acks_o = 0;
    rd_o = 'x;
    err_o = 1'bx;
    @(negedge clk);
    reg_wr = w;
    reg_rd = r;
    reg_addr = a;
    reg_wr_data = d;
    while (acks_o == 0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      bd_wr = bd && cyc == 1;
      bd_op_type = bd_val;
      if (reg_ack) begin
        acks_o++;
        lat = cyc;
        rd_o = reg_rd_data;
        err_o = reg_err;
      end
    end
    bd_wr = 1'b0;
    if (acks_o == 0) chk("ack_timeout", 32'd0, 32'd1);
    else chk("latency", lat, 3);
    repeat (hold) begin
      @(negedge clk);
      if (reg_ack) acks_o++;
    end
    reg_wr = 1'b0;
    reg_rd = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (reg_ack) acks_o++;
    end
  endtask
  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] v;
    logic        e;
    int          n;
    xfer(1'b0, 1'b1, a, 32'd0, 0, 1'b0, 2'd0, v, e, n);
    chk({tag, "_data"}, v, exp);
    chk({tag, "_err"}, e, 1'b0);
  endtask
  initial begin
    int seen;
    repeat (2) @(negedge clk);
    chk("rst_ack", reg_ack, 0);
    chk("rst_err", reg_err, 0);
    chk("rst_rdata", reg_rd_data, 0);
    chk("rst_op", op_type, 0);
    rst_n = 1'b1;
    xfer(1'b1, 1'b0, 32'd10, 32'd1, 5, 1'b0, 2'd0, rdata, err, acks);
    chk("held_acks", acks, 1);
    chk("held_err", err, 0);
    chk("held_op", op_type, 1);
    rd(32'd12, 32'd1, "wrc1");
    xfer(1'b1, 1'b0, 32'd10, 32'd2, 0, 1'b0, 2'd0, rdata, err, acks);
    rd(32'd10, 32'd2, "op_rd");
    xfer(1'b1, 1'b0, 32'd10, 32'd5, 0, 1'b0, 2'd0, rdata, err, acks);
    chk("op_bad_err", err, 1);
    chk("op_bad_op", op_type, 2);
    rd(32'd13, 32'd1, "errc1");
    rd(32'd14, 32'd1, "sticky");
    rd(32'd12, 32'd2, "wrc2");
    xfer(1'b1, 1'b0, 32'd20, 32'hAA, 0, 1'b0, 2'd0, rdata, err, acks);
    chk("oor_wr_err", err, 1);
    xfer(1'b0, 1'b1, 32'd9, 32'd0, 0, 1'b0, 2'd0, rdata, err, acks);
    chk("oor_rd_err", err, 1);
    chk("oor_rd_data", rdata, 0);
    rd(32'd13, 32'd3, "errc3");
    rd(32'd12, 32'd2, "wrc_oor");
    xfer(1'b1, 1'b0, 32'd14, 32'd1, 0, 1'b0, 2'd0, rdata, err, acks);
    chk("w1c_err", err, 0);
    rd(32'd14, 32'd0, "status_clr");
    xfer(1'b1, 1'b0, 32'd11, 32'hDEADBEEF, 0, 1'b0, 2'd0, rdata, err, acks);
    rd(32'd11, 32'hDEADBEEF, "scratch");
    xfer(1'b1, 1'b0, 32'd12, 32'd7, 0, 1'b0, 2'd0, rdata, err, acks);
    chk("ro_err", err, 1);
    rd(32'd12, 32'd4, "ro_wrc");
    xfer(1'b1, 1'b0, 32'd10, 32'd1, 0, 1'b1, 2'd3, rdata, err, acks);
    chk("bd_col_err", err, 0);
    chk("bd_col_op", op_type, 3);
    rd(32'd12, 32'd5, "bd_wrc");
    @(negedge clk);
    bd_wr = 1'b1;
    bd_op_type = 2'd0;
    @(negedge clk);
    bd_wr = 1'b0;
    chk("bd_idle_op", op_type, 0);
    rd(32'd12, 32'd5, "bd_idle_wrc");
    xfer(1'b1, 1'b1, 32'd11, 32'd5, 0, 1'b0, 2'd0, rdata, err, acks);
    chk("both_err", err, 1);
    rd(32'd11, 32'hDEADBEEF, "both_scratch");
    rd(32'd13, 32'd5, "errc5");
    @(negedge clk);
    bd_wr = 1'b1;
    bd_op_type = 2'd2;
    @(negedge clk);
    bd_wr = 1'b0;
    seen = 0;
    reg_wr = 1'b1;
    reg_addr = 32'd10;
    reg_wr_data = 32'd1;
    @(negedge clk);
    rst_n = 1'b0;
    reg_wr = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (reg_ack) seen++;
    end
    chk("rst_mid_ack", seen, 0);
    chk("rst_mid_op", op_type, 0);
    reg_rd = 1'b1;
    reg_addr = 32'd14;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      @(negedge clk);
      if (reg_ack) seen++;
    end
    chk("post_rst_req_ack", seen, 1);
    reg_rd = 1'b0;
    repeat (3) @(negedge clk);
    rd(32'd12, 32'd0, "rst_wrc");
    rd(32'd13, 32'd0, "rst_errc");
    rd(32'd11, 32'd0, "rst_scratch");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
